cam_request_scheduler: RTL
==========================

// Module: cam_request_scheduler
// PURPOSE
//  Front-end for Content_Addressable_Memory: queues write/search requests from a valid/ready producer.
//  Drives the CAM's wen/ren/din/addr with one op per cycle; captures the CAM's dout/hit for each search.
//  Returns search results in order on a valid/ready response port; writes return no response.
// PARAMETERS
//  DATA_W  8  key/data width (CAM din)
//  ADDR_W  4  CAM address width (2**ADDR_W entries)
//  QDEPTH  4  entries in request FIFO and in response FIFO (power of 2, >=2)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       request offered
//  req_ready  out  1       request FIFO not full; accept when valid&ready at posedge
//  req_op     in   1       0=search, 1=write
//  req_data   in   DATA_W  key (search) / data (write)
//  req_addr   in   ADDR_W  write address; ignored for search
//  rsp_valid  out  1       response FIFO not empty
//  rsp_ready  in   1       consumer pops head at posedge when valid&ready
//  rsp_hit    out  1       head result: match found
//  rsp_addr   out  ADDR_W  head result: matching address (0 on miss)
//  cam_wen    out  1       CAM write enable
//  cam_ren    out  1       CAM read/search enable
//  cam_din    out  DATA_W  CAM data/key
//  cam_addr   out  ADDR_W  CAM write address
//  cam_dout   in   ADDR_W  CAM result address, valid cycle after cam_ren
//  cam_hit    in   1       CAM hit flag, valid cycle after cam_ren
// BEHAVIOUR
//  Reset (async, immediate): FIFOs empty, credits=QDEPTH, pipe flag=0; req_ready=1, rsp_valid=0,
//   rsp_hit=0, rsp_addr=0, cam_wen=0, cam_ren=0, cam_din=0, cam_addr=0. In-flight search discarded.
//  Issue stage (combinational off req FIFO head, registered cam_* outputs):
//   head=write -> cam_wen=1,cam_ren=0 for one cycle, popped; always issuable.
//   head=search -> issued only if credits>0: cam_ren=1,cam_wen=0, credits-1, pipe flag set.
//   Never wen&ren together; idle cycles drive both 0, cam_din/addr hold last value.
//  Credits = free rsp slots minus in-flight searches; +1 on each rsp pop, -1 on each search issue
//   (same-cycle both -> unchanged). Guarantees response FIFO never overflows.
//  Capture: cycle after a search issue, {cam_hit, cam_hit?cam_dout:0} pushed to rsp FIFO.
//  Latency: request accepted at edge k -> cam op at edge k+1 -> rsp_valid high after edge k+2
//   (search with empty queues). Throughput 1 op/cycle, writes and searches interleaved freely.
//  Ordering: strict program order; search issued cycle after a write sees that write.
//  Full: req_ready=0 when req FIFO holds QDEPTH; simultaneous push+pop when full is not allowed
//   (ready already low). Empty rsp FIFO: rsp_ready ignored. Pointers wrap mod QDEPTH.
//  FSM (issue): IDLE (req FIFO empty) -> RUN (issuing) -> STALL (head=search, credits=0);
//   STALL->RUN on credit return; RUN->IDLE when FIFO drains.
// CONFIGURATION
//  CAM_STATS_EN defined: adds outputs stat_hit[7:0], stat_miss[7:0]; +1 per captured search result,
//   saturate at 255, cleared by rst_n. Undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  1 write din=10 addr=C, then search 10 -> one rsp: hit=1 addr=C; no rsp for the write.
//  2 search 99 on unmatched CAM -> hit=0 addr=0; rsp_valid after edge k+2.
//  3 rsp_ready=0, 12 back-to-back searches -> exactly 8 accepted, 4 cam_ren pulses then none;
//    release rsp_ready -> 8 responses in request order, remaining searches then flow.
//  4 write 30@2 then search 30 on next cycle -> hit=1 addr=2 (no stale miss).
//  5 rst_n low with 3 queued + 1 in flight -> all outputs reset at once, no rsp after release.
//  6 CAM_STATS_EN: 3 hits + 2 misses -> stat_hit=3, stat_miss=2; 300 hits -> stat_hit=255.

Source files
------------

// File: rtl/cam_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cam_request_scheduler
// Brief    : In-order write/search request scheduler in front of a CAM, with
//            credit-based response buffering. Optional CAM_STATS_EN adds
//            saturating hit/miss counters (stat_hit, stat_miss).
// Revision : 1.0 - initial release
// ============================================================================
module cam_request_scheduler #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              cam_wen,
    output logic              cam_ren,
    output logic [DATA_W-1:0] cam_din,
    output logic [ADDR_W-1:0] cam_addr,
    input  logic [ADDR_W-1:0] cam_dout,
    input  logic              cam_hit
`ifdef CAM_STATS_EN
    ,
    output logic [7:0]        stat_hit,
    output logic [7:0]        stat_miss
`endif
);

    localparam int c_ptr_w = $clog2(QDEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_req_w = DATA_W + ADDR_W + 1;
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(QDEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_stall = 2'd2;

    logic [c_req_w-1:0] r_req_mem [QDEPTH];
    logic [c_ptr_w-1:0] r_req_wr;
    logic [c_ptr_w-1:0] r_req_rd;
    logic [c_cnt_w-1:0] r_req_cnt;

    logic [ADDR_W:0]    r_rsp_mem [QDEPTH];
    logic [c_ptr_w-1:0] r_rsp_wr;
    logic [c_ptr_w-1:0] r_rsp_rd;
    logic [c_cnt_w-1:0] r_rsp_cnt;

    logic               r_pipe;
    logic [c_cnt_w-1:0] r_credits;

    logic               w_head_op;
    logic [DATA_W-1:0]  w_head_data;
    logic [ADDR_W-1:0]  w_head_addr;
    logic               w_req_push;
    logic               w_rsp_pop;
    logic               w_issue;
    logic               w_issue_wr;
    logic               w_issue_sr;
    logic [1:0]         w_state;

    assign req_ready  = (r_req_cnt != c_full);
    assign w_req_push = req_valid & req_ready;
    assign {w_head_op, w_head_data, w_head_addr} = r_req_mem[r_req_rd];

    assign rsp_valid  = (r_rsp_cnt != '0);
    assign w_rsp_pop  = rsp_valid & rsp_ready;
    assign rsp_hit    = rsp_valid & r_rsp_mem[r_rsp_rd][ADDR_W];
    assign rsp_addr   = rsp_valid ? r_rsp_mem[r_rsp_rd][ADDR_W-1:0] : '0;

    // Issue state is decoded from the live FIFO head so a request can issue
    // the very cycle after it lands, keeping one op per cycle.
    always_comb begin
        w_state = c_run;
        if (r_req_cnt == '0) begin
            w_state = c_idle;
        end else if (!w_head_op && (r_credits == '0)) begin
            w_state = c_stall;
        end
    end

    assign w_issue    = (w_state == c_run);
    assign w_issue_wr = w_issue & w_head_op;
    assign w_issue_sr = w_issue & ~w_head_op;

    always_ff @(posedge clk) begin
        if (w_req_push) begin
            r_req_mem[r_req_wr] <= {req_op, req_data, req_addr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_wr  <= '0;
            r_req_rd  <= '0;
            r_req_cnt <= '0;
        end else begin
            if (w_req_push) r_req_wr <= r_req_wr + c_ptr_one;
            if (w_issue)    r_req_rd <= r_req_rd + c_ptr_one;
            case ({w_req_push, w_issue})
                2'b10:   r_req_cnt <= r_req_cnt + c_cnt_one;
                2'b01:   r_req_cnt <= r_req_cnt - c_cnt_one;
                default: r_req_cnt <= r_req_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_wen  <= 1'b0;
            cam_ren  <= 1'b0;
            cam_din  <= '0;
            cam_addr <= '0;
            r_pipe   <= 1'b0;
        end else begin
            cam_wen <= w_issue_wr;
            cam_ren <= w_issue_sr;
            r_pipe  <= w_issue_sr;
            if (w_issue)    cam_din  <= w_head_data;
            if (w_issue_wr) cam_addr <= w_head_addr;
        end
    end

    // A credit stands for one response slot not yet claimed by a search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= c_full;
        end else begin
            case ({w_rsp_pop, w_issue_sr})
                2'b10:   r_credits <= r_credits + c_cnt_one;
                2'b01:   r_credits <= r_credits - c_cnt_one;
                default: r_credits <= r_credits;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_pipe) begin
            r_rsp_mem[r_rsp_wr] <= {cam_hit, (cam_hit ? cam_dout : {ADDR_W{1'b0}})};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_wr  <= '0;
            r_rsp_rd  <= '0;
            r_rsp_cnt <= '0;
        end else begin
            if (r_pipe)    r_rsp_wr <= r_rsp_wr + c_ptr_one;
            if (w_rsp_pop) r_rsp_rd <= r_rsp_rd + c_ptr_one;
            case ({r_pipe, w_rsp_pop})
                2'b10:   r_rsp_cnt <= r_rsp_cnt + c_cnt_one;
                2'b01:   r_rsp_cnt <= r_rsp_cnt - c_cnt_one;
                default: r_rsp_cnt <= r_rsp_cnt;
            endcase
        end
    end

`ifdef CAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hit  <= 8'd0;
            stat_miss <= 8'd0;
        end else if (r_pipe) begin
            if (cam_hit) begin
                if (stat_hit != 8'hFF) stat_hit <= stat_hit + 8'd1;
            end else begin
                if (stat_miss != 8'hFF) stat_miss <= stat_miss + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
